// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the instruction-phase sequencer and the datapath decode.
package phase_seq_pkg;

  localparam int DEFAULT_NUM_PHASES = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_STEP = 2'd2;

endpackage

// File: rtl/phase_sequencer.sv
// Steps a phase counter through NUM_PHASES phases per instruction and drives one-hot
// phase enables, with run/stop, single-step, stall, early termination and a retire counter.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = DEFAULT_NUM_PHASES,
  parameter int ICNT_W     = 32,
  localparam int PHASE_W   = $clog2(NUM_PHASES)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_end_early,
  output logic [PHASE_W-1:0]    o_phase,
  output logic [NUM_PHASES-1:0] o_phase_en,
  output logic                  o_running,
  output logic                  o_insn_done,
  output logic [ICNT_W-1:0]     o_insn_count
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_t              r_state;
  state_t              w_state_d;
  logic [PHASE_W-1:0]  r_phase;
  logic [PHASE_W-1:0]  w_phase_d;
  logic [ICNT_W-1:0]   r_count;
  logic [ICNT_W-1:0]   w_count_d;
  logic                w_active;
  logic                w_advance;
  logic                w_boundary;

  assign w_active   = (r_state != ST_IDLE);
  // A stalled phase neither advances nor may terminate the instruction.
  assign w_advance  = w_active && !i_stall;
  assign w_boundary = w_advance && ((r_phase == LAST_PHASE) || i_end_early);

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_count_d = r_count;
    if (r_state == ST_IDLE) begin
      w_phase_d = '0;
      if (i_run) begin
        w_state_d = ST_RUN;
      end else if (i_step) begin
        w_state_d = ST_STEP;
      end
    end else if (w_boundary) begin
      w_phase_d = '0;
      w_count_d = r_count + ICNT_W'(1);
      w_state_d = ((r_state == ST_RUN) && i_run) ? ST_RUN : ST_IDLE;
    end else if (w_advance) begin
      w_phase_d = r_phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_count <= w_count_d;
    end
  end

  always_comb begin
    o_phase_en = '0;
    if (w_advance) begin
      o_phase_en = NUM_PHASES'(1) << r_phase;
    end
  end

  assign o_phase      = r_phase;
  assign o_running    = w_active;
  assign o_insn_done  = w_boundary;
  assign o_insn_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Vector/scoreboard bench for phase_sequencer: a 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus.
module tb_phase_sequencer;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic        stall;
    logic        ee;
    logic [2:0]  ph;
    logic [4:0]  en;
    logic        rn;
    logic        dn;
    logic [31:0] cnt;
  } vec_t;

  logic        clk;
  logic        reset, run, step, stall, end_early;
  logic [2:0]  phase, phase4;
  logic [4:0]  phase_en, phase_en4;
  logic        running, running4, insn_done, insn_done4;
  logic [31:0] insn_count;
  logic [3:0]  insn_count4;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  phase_sequencer #(.NUM_PHASES(5), .ICNT_W(32)) dut (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_run        (run),
    .i_step       (step),
    .i_stall      (stall),
    .i_end_early  (end_early),
    .o_phase      (phase),
    .o_phase_en   (phase_en),
    .o_running    (running),
    .o_insn_done  (insn_done),
    .o_insn_count (insn_count)
  );

  phase_sequencer #(.NUM_PHASES(5), .ICNT_W(4)) dut4 (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_run        (run),
    .i_step       (step),
    .i_stall      (stall),
    .i_end_early  (end_early),
    .o_phase      (phase4),
    .o_phase_en   (phase_en4),
    .o_running    (running4),
    .o_insn_done  (insn_done4),
    .o_insn_count (insn_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(int rst_v, int run_v, int step_v, int stall_v, int ee_v,
                              int ph_v, int en_v, int rn_v, int dn_v, int cnt_v);
    vec_t v;
    v.rst = rst_v[0];  v.run = run_v[0]; v.step = step_v[0]; v.stall = stall_v[0];
    v.ee  = ee_v[0];   v.ph = ph_v[2:0]; v.en = en_v[4:0];   v.rn = rn_v[0];
    v.dn  = dn_v[0];   v.cnt = cnt_v;
    return v;
  endfunction

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
  task automatic apply(vec_t v, int row);
    vec_t e;
    reset = v.rst; run = v.run; step = v.step; stall = v.stall; end_early = v.ee;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("phase", row, 32'(phase), 32'(e.ph));
    chk("phase_en", row, 32'(phase_en), 32'(e.en));
    chk("running", row, 32'(running), 32'(e.rn));
    chk("insn_done", row, 32'(insn_done), 32'(e.dn));
    chk("insn_count", row, insn_count, e.cnt);
    chk("insn_count4", row, 32'(insn_count4), 32'(e.cnt[3:0]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst run step stall ee | phase en running done count
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 0,  0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 3,  8,1,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 4, 16,1,1, 0));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 3,  8,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 4, 16,1,1, 1));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 2));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 2));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 2));
    vecs.push_back(mk(0,1,0,0,0, 3,  8,1,0, 2));
    vecs.push_back(mk(0,1,0,0,0, 4, 16,1,1, 2));
    // run dropped at phase 1: instruction completes, then idle
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 1,  2,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 2,  4,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 3,  8,1,0, 3));
    vecs.push_back(mk(0,0,0,0,0, 4, 16,1,1, 3));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 4));
    // single step pulse
    vecs.push_back(mk(0,0,1,0,0, 0,  0,0,0, 4));
    vecs.push_back(mk(0,0,0,0,0, 0,  1,1,0, 4));
    vecs.push_back(mk(0,0,0,0,0, 1,  2,1,0, 4));
    vecs.push_back(mk(0,0,0,0,0, 2,  4,1,0, 4));
    vecs.push_back(mk(0,0,0,0,0, 3,  8,1,0, 4));
    vecs.push_back(mk(0,0,0,0,0, 4, 16,1,1, 4));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 5));
    // step held high: one instruction per idle visit
    vecs.push_back(mk(0,0,1,0,0, 0,  0,0,0, 5));
    vecs.push_back(mk(0,0,1,0,0, 0,  1,1,0, 5));
    vecs.push_back(mk(0,0,1,0,0, 1,  2,1,0, 5));
    vecs.push_back(mk(0,0,1,0,0, 2,  4,1,0, 5));
    vecs.push_back(mk(0,0,1,0,0, 3,  8,1,0, 5));
    vecs.push_back(mk(0,0,1,0,0, 4, 16,1,1, 5));
    vecs.push_back(mk(0,0,1,0,0, 0,  0,0,0, 6));
    vecs.push_back(mk(0,0,0,0,0, 0,  1,1,0, 6));
    vecs.push_back(mk(0,0,0,0,0, 1,  2,1,0, 6));
    vecs.push_back(mk(0,0,0,0,0, 2,  4,1,0, 6));
    vecs.push_back(mk(0,0,0,0,0, 3,  8,1,0, 6));
    vecs.push_back(mk(0,0,0,0,0, 4, 16,1,1, 6));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 7));
    // end_early at phase 2 (step in RUN ignored)
    vecs.push_back(mk(0,1,0,0,0, 0,  0,0,0, 7));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 7));
    vecs.push_back(mk(0,1,1,0,0, 1,  2,1,0, 7));
    vecs.push_back(mk(0,1,0,0,1, 2,  4,1,1, 7));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 8));
    // 4-cycle stall at phase 1, end_early ignored while stalled: 9-cycle instruction
    vecs.push_back(mk(0,1,0,1,0, 1,  0,1,0, 8));
    vecs.push_back(mk(0,1,0,1,1, 1,  0,1,0, 8));
    vecs.push_back(mk(0,1,0,1,0, 1,  0,1,0, 8));
    vecs.push_back(mk(0,1,0,1,0, 1,  0,1,0, 8));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 8));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 8));
    vecs.push_back(mk(0,1,0,0,0, 3,  8,1,0, 8));
    vecs.push_back(mk(0,1,0,0,0, 4, 16,1,1, 8));
    // reset at phase 3 wins over run
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 9));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 9));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 9));
    vecs.push_back(mk(1,1,0,0,0, 3,  8,1,0, 9));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 0));
    // one-phase instruction, run low at the boundary
    vecs.push_back(mk(0,1,0,0,0, 0,  0,0,0, 0));
    vecs.push_back(mk(0,0,0,0,1, 0,  1,1,1, 0));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 1));
    // end_early on the final phase counts once; stall ignored in idle
    vecs.push_back(mk(0,1,0,0,0, 0,  0,0,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 0,  1,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 1,  2,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 2,  4,1,0, 1));
    vecs.push_back(mk(0,1,0,0,0, 3,  8,1,0, 1));
    vecs.push_back(mk(0,0,0,0,1, 4, 16,1,1, 1));
    vecs.push_back(mk(0,0,0,1,0, 0,  0,0,0, 2));
    vecs.push_back(mk(0,0,0,0,0, 0,  0,0,0, 2));

    reset = 1'b1; run = 1'b0; step = 1'b0; stall = 1'b0; end_early = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Counter wrap: 17 back-to-back instructions; the 4-bit instance wraps 15 -> 0.
    apply(mk(1,1,0,0,0, 0, 0,0,0, 2), 1000);
    apply(mk(0,1,0,0,0, 0, 0,0,0, 0), 1001);
    for (int i = 0; i < 85; i++) begin
      apply(mk(0,1,0,0,0, i % 5, 1 << (i % 5), 1, ((i % 5) == 4) ? 1 : 0, i / 5), 2000 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
